// File: rtl/mem_result_checker_if.sv
// mem_result_checker_if: config, snoop and result signals of the end-of-program result checker.
//   master: drives cfg_*, start, halt and the mem_* snoop, and reads the results.
//   slave : the checker itself.
//   Results: busy, done, pass, timed_out, fail_mask[NUM_CHECKS], cycles[TIMEOUT_W].
interface mem_result_checker_if #(
    parameter int ADDR_W     = 16,
    parameter int DATA_W     = 16,
    parameter int NUM_CHECKS = 4,
    parameter int TIMEOUT_W  = 24
) ();
    localparam int IDX_W = NUM_CHECKS > 1 ? $clog2(NUM_CHECKS) : 1;
    logic                  cfg_we;
    logic [IDX_W-1:0]      cfg_idx;
    logic                  cfg_en;
    logic [ADDR_W-1:0]     cfg_addr;
    logic [DATA_W-1:0]     cfg_data;
    logic                  start;
    logic                  halt;
    logic                  mem_we;
    logic [ADDR_W-1:0]     mem_addr;
    logic [DATA_W-1:0]     mem_wdata;
    logic                  busy;
    logic                  done;
    logic                  pass;
    logic                  timed_out;
    logic [NUM_CHECKS-1:0] fail_mask;
    logic [TIMEOUT_W-1:0]  cycles;
    modport master (
        output cfg_we, cfg_idx, cfg_en, cfg_addr, cfg_data, start, halt, mem_we, mem_addr, mem_wdata,
        input  busy, done, pass, timed_out, fail_mask, cycles
    );
    modport slave (
        input  cfg_we, cfg_idx, cfg_en, cfg_addr, cfg_data, start, halt, mem_we, mem_addr, mem_wdata,
        output busy, done, pass, timed_out, fail_mask, cycles
    );
endinterface

// File: rtl/mem_result_checker.sv
// mem_result_checker: snoops data-memory writes to watched addresses and checks them against expected values at halt/timeout.
//   clk   : system clock, rising edge
//   reset : synchronous, active-low
//   bus   : mem_result_checker_if.slave (config, start/halt, write snoop in; busy/done/pass/timed_out/fail_mask/cycles out)
module mem_result_checker #(
    parameter int ADDR_W          = 16,
    parameter int DATA_W          = 16,
    parameter int NUM_CHECKS      = 4,
    parameter int TIMEOUT_W       = 24,
    parameter int TIMEOUT_CYCLES  = 200000,
    parameter bit TIMEOUT_IS_FAIL = 1'b0,
    parameter bit EARLY_PASS      = 1'b0
) (
    input logic                clk,
    input logic                reset,
    mem_result_checker_if.slave bus
);
    localparam int IDX_W = NUM_CHECKS > 1 ? $clog2(NUM_CHECKS) : 1;
    typedef enum logic [1:0] {IDLE, RUN, CHECK, DONE} state_t;
    state_t                state;
    logic [NUM_CHECKS-1:0] en;
    logic [NUM_CHECKS-1:0] seen;
    logic [ADDR_W-1:0]     addr [NUM_CHECKS];
    logic [DATA_W-1:0]     expv [NUM_CHECKS];
    logic [DATA_W-1:0]     last [NUM_CHECKS];
    logic [NUM_CHECKS-1:0] hit;
    logic [NUM_CHECKS-1:0] bad;
    logic                  timeout;
    logic                  finish;
    for (genvar i = 0; i < NUM_CHECKS; i++) begin : g_entry
        assign hit[i] = en[i] & bus.mem_we & (addr[i] == bus.mem_addr);
        assign bad[i] = en[i] & (~seen[i] | (last[i] != expv[i]));
    end
    assign timeout = bus.cycles == TIMEOUT_W'(TIMEOUT_CYCLES - 1);
    // Early exit looks only at registered seen/last, so a matching write ends the run one edge later.
    assign finish  = bus.halt | timeout | (EARLY_PASS & ~|bad);
    always_ff @(posedge clk) begin
        if (!reset) begin
            state         <= IDLE;
            en            <= '0;
            seen          <= '0;
            for (int i = 0; i < NUM_CHECKS; i++) begin
                addr[i] <= '0;
                expv[i] <= '0;
                last[i] <= '0;
            end
            bus.busy      <= 1'b0;
            bus.done      <= 1'b0;
            bus.pass      <= 1'b0;
            bus.timed_out <= 1'b0;
            bus.fail_mask <= '0;
            bus.cycles    <= '0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    if (bus.cfg_we)
                        for (int i = 0; i < NUM_CHECKS; i++)
                            if (bus.cfg_idx == IDX_W'(i)) begin
                                en[i]   <= bus.cfg_en;
                                addr[i] <= bus.cfg_addr;
                                expv[i] <= bus.cfg_data;
                            end
                    if (bus.start) begin
                        state         <= RUN;
                        seen          <= '0;
                        for (int i = 0; i < NUM_CHECKS; i++) last[i] <= '0;
                        bus.busy      <= 1'b1;
                        bus.done      <= 1'b0;
                        bus.pass      <= 1'b0;
                        bus.timed_out <= 1'b0;
                        bus.fail_mask <= '0;
                        bus.cycles    <= '0;
                    end
                end
                RUN: begin
                    // Every enabled entry on the address captures, so duplicates all track the latest write.
                    for (int i = 0; i < NUM_CHECKS; i++)
                        if (hit[i]) last[i] <= bus.mem_wdata;
                    seen <= seen | hit;
                    if (finish) begin
                        state         <= CHECK;
                        bus.timed_out <= timeout & ~bus.halt;
                    end else begin
                        bus.cycles <= bus.cycles + 1'b1;
                    end
                end
                CHECK: begin
                    state         <= DONE;
                    bus.busy      <= 1'b0;
                    bus.done      <= 1'b1;
                    bus.fail_mask <= bad;
                    // An empty check set never passes.
                    bus.pass      <= ~|bad & |en & ~(TIMEOUT_IS_FAIL & bus.timed_out);
                end
            endcase
        end
    end
endmodule

// File: tb/tb_mem_result_checker.sv
// tb_mem_result_checker: three checker variants (plain, timeout-is-fail, early-pass) driven by shared stimulus.
module tb_mem_result_checker;
    logic clk = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;
    logic        cfg_we = 0, cfg_en = 0, start = 0, halt = 0, mem_we = 0;
    logic [1:0]  cfg_idx = 0;
    logic [15:0] cfg_addr = 0, cfg_data = 0, mem_addr = 0, mem_wdata = 0;
    wire  [2:0]  o_busy, o_done, o_pass, o_to;
    wire  [3:0]  o_fm  [3];
    wire  [23:0] o_cyc [3];
    int checks = 0;
    int failures = 0;
    logic [3:0]  m_en;
    logic [15:0] m_addr [4];
    logic [15:0] m_exp  [4];
    logic        s_we [100];
    logic        s_h  [100];
    logic [15:0] s_addr [100];
    logic [15:0] s_data [100];

    for (genvar g = 0; g < 3; g++) begin : gd
        mem_result_checker_if bus ();
        assign bus.cfg_we    = cfg_we;
        assign bus.cfg_idx   = cfg_idx;
        assign bus.cfg_en    = cfg_en;
        assign bus.cfg_addr  = cfg_addr;
        assign bus.cfg_data  = cfg_data;
        assign bus.start     = start;
        assign bus.halt      = halt;
        assign bus.mem_we    = mem_we;
        assign bus.mem_addr  = mem_addr;
        assign bus.mem_wdata = mem_wdata;
        assign o_busy[g] = bus.busy;
        assign o_done[g] = bus.done;
        assign o_pass[g] = bus.pass;
        assign o_to[g]   = bus.timed_out;
        assign o_fm[g]   = bus.fail_mask;
        assign o_cyc[g]  = bus.cycles;
        mem_result_checker #(
            .TIMEOUT_CYCLES(100),
            .TIMEOUT_IS_FAIL(g == 1),
            .EARLY_PASS(g == 2)
        ) dut (
            .clk(clk),
            .reset(reset),
            .bus(bus.slave)
        );
    end

    typedef struct packed {
        logic [3:0]       en;
        logic [15:0]      a0, d0, a1, d1;
        logic [1:0]       nw;
        logic [2:0][15:0] wa, wd;
        logic             ps;
        logic [3:0]       fm;
        logic [23:0]      cyc;
    } vec_t;
    vec_t tv [8];

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", n, act, exp);
        end
    endtask

    task automatic cfg(input int i, input logic e, input logic [15:0] a, input logic [15:0] d);
        cfg_we = 1; cfg_idx = 2'(i); cfg_en = e; cfg_addr = a; cfg_data = d;
        tick;
        cfg_we = 0;
        m_en[i] = e; m_addr[i] = a; m_exp[i] = d;
    endtask

    task automatic clr_sched;
        for (int k = 0; k < 100; k++) begin
            s_we[k] = 0; s_h[k] = 0; s_addr[k] = 0; s_data[k] = 0;
        end
    endtask

    task automatic run(input int last_k);
        start = 1;
        tick;
        start = 0; cfg_we = 0;
        for (int k = 0; k <= last_k; k++) begin
            mem_we = s_we[k]; mem_addr = s_addr[k]; mem_wdata = s_data[k]; halt = s_h[k];
            tick;
        end
        mem_we = 0; halt = 0;
        tick;
    endtask

    // Run-level reference: last write per watched address, exit at first halt/timeout/early-all-good cycle.
    function automatic void model(input bit early, input bit tif, output int kx,
                                  output logic [3:0] fm, output logic ps, output logic to);
        logic [15:0] lst [4];
        logic [3:0]  sn;
        bit ok;
        sn = 0; kx = 99; to = 0;
        for (int i = 0; i < 4; i++) lst[i] = 0;
        for (int k = 0; k < 100; k++) begin
            ok = early;
            for (int i = 0; i < 4; i++)
                if (m_en[i] && !(sn[i] && lst[i] == m_exp[i])) ok = 0;
            if (s_we[k])
                for (int i = 0; i < 4; i++)
                    if (m_en[i] && m_addr[i] == s_addr[k]) begin
                        lst[i] = s_data[k]; sn[i] = 1;
                    end
            if (s_h[k] || k == 99 || ok) begin
                kx = k; to = (k == 99) && !s_h[k];
                break;
            end
        end
        for (int i = 0; i < 4; i++) fm[i] = m_en[i] && (!sn[i] || lst[i] != m_exp[i]);
        ps = (fm == 0) && (m_en != 0) && !(tif && to);
    endfunction

    task automatic check_run(input string n);
        int kx; logic [3:0] fm; logic ps, to;
        for (int g = 0; g < 3; g++) begin
            model(g == 2, g == 1, kx, fm, ps, to);
            chk($sformatf("%s_d%0d_done", n, g), o_done[g], 1);
            chk($sformatf("%s_d%0d_busy", n, g), o_busy[g], 0);
            chk($sformatf("%s_d%0d_pass", n, g), o_pass[g], ps);
            chk($sformatf("%s_d%0d_mask", n, g), o_fm[g], fm);
            chk($sformatf("%s_d%0d_to", n, g), o_to[g], to);
            chk($sformatf("%s_d%0d_cyc", n, g), o_cyc[g], kx);
        end
    endtask

    task automatic check_zero(input string n);
        for (int g = 0; g < 3; g++) begin
            chk($sformatf("%s_d%0d_busy", n, g), o_busy[g], 0);
            chk($sformatf("%s_d%0d_done", n, g), o_done[g], 0);
            chk($sformatf("%s_d%0d_pass", n, g), o_pass[g], 0);
            chk($sformatf("%s_d%0d_to", n, g), o_to[g], 0);
            chk($sformatf("%s_d%0d_mask", n, g), o_fm[g], 0);
            chk($sformatf("%s_d%0d_cyc", n, g), o_cyc[g], 0);
        end
    endtask

    initial begin
        int kx; logic [3:0] fm; logic ps, to;
        tv[0] = '{4'b0001, 16'hFF, 16'h0D, 16'h0, 16'h0, 2'd1, {16'h0, 16'h0, 16'hFF}, {16'h0, 16'h0, 16'h0D}, 1'b1, 4'b0000, 24'd1};
        tv[1] = '{4'b0001, 16'hFF, 16'h0D, 16'h0, 16'h0, 2'd3, {16'hFF, 16'hFF, 16'hFF}, {16'h15, 16'h0D, 16'h08}, 1'b0, 4'b0001, 24'd3};
        tv[2] = '{4'b0011, 16'h10, 16'h5, 16'h11, 16'h7, 2'd1, {16'h0, 16'h0, 16'h10}, {16'h0, 16'h0, 16'h5}, 1'b0, 4'b0010, 24'd1};
        tv[3] = '{4'b0011, 16'h10, 16'h5, 16'h11, 16'h7, 2'd3, {16'h12, 16'h11, 16'h10}, {16'h9, 16'h7, 16'h5}, 1'b1, 4'b0000, 24'd3};
        tv[4] = '{4'b0000, 16'hFF, 16'h0D, 16'h0, 16'h0, 2'd1, {16'h0, 16'h0, 16'hFF}, {16'h0, 16'h0, 16'h0D}, 1'b0, 4'b0000, 24'd1};
        tv[5] = '{4'b0011, 16'h20, 16'h1, 16'h20, 16'h2, 2'd1, {16'h0, 16'h0, 16'h20}, {16'h0, 16'h0, 16'h1}, 1'b0, 4'b0010, 24'd1};
        tv[6] = '{4'b0001, 16'hFF, 16'h0D, 16'h11, 16'h7, 2'd2, {16'h0, 16'h11, 16'hFF}, {16'h0, 16'h3, 16'h0D}, 1'b1, 4'b0000, 24'd2};
        tv[7] = '{4'b0001, 16'hFF, 16'h0D, 16'h0, 16'h0, 2'd0, {16'h0, 16'h0, 16'h0}, {16'h0, 16'h0, 16'h0}, 1'b0, 4'b0001, 24'd0};
        m_en = 0;
        for (int i = 0; i < 4; i++) begin m_addr[i] = 0; m_exp[i] = 0; end
        tick; tick;
        check_zero("reset");
        reset = 1;
        tick;
        for (int v = 0; v < 8; v++) begin
            cfg(0, tv[v].en[0], tv[v].a0, tv[v].d0);
            cfg(1, tv[v].en[1], tv[v].a1, tv[v].d1);
            cfg(2, 0, 0, 0);
            cfg(3, 0, 0, 0);
            clr_sched;
            for (int j = 0; j < int'(tv[v].nw); j++) begin
                s_we[j] = 1; s_addr[j] = tv[v].wa[j]; s_data[j] = tv[v].wd[j];
            end
            s_h[tv[v].nw] = 1;
            run(int'(tv[v].nw));
            chk($sformatf("vec%0d_done", v), o_done[0], 1);
            chk($sformatf("vec%0d_pass", v), o_pass[0], tv[v].ps);
            chk($sformatf("vec%0d_mask", v), o_fm[0], tv[v].fm);
            chk($sformatf("vec%0d_cyc", v), o_cyc[0], tv[v].cyc);
        end
        // Timeout with a correct write; watch the run-to-check-to-done latency on the way.
        cfg(0, 1, 16'hFF, 16'h0D);
        cfg(1, 0, 0, 0);
        clr_sched;
        s_we[0] = 1; s_addr[0] = 16'hFF; s_data[0] = 16'h0D;
        start = 1; tick; start = 0;
        for (int k = 0; k < 100; k++) begin
            mem_we = s_we[k]; mem_addr = s_addr[k]; mem_wdata = s_data[k];
            if (k == 99) begin
                chk("tmo_pre_busy", o_busy[0], 1);
                chk("tmo_pre_done", o_done[0], 0);
            end
            tick;
        end
        mem_we = 0;
        chk("tmo_check_busy", o_busy[0], 1);
        chk("tmo_check_done", o_done[0], 0);
        tick;
        check_run("tmo");
        chk("tmo_d0_timed_out", o_to[0], 1);
        chk("tmo_d0_cycles", o_cyc[0], 99);
        chk("tmo_d0_pass", o_pass[0], 1);
        chk("tmo_d1_pass", o_pass[1], 0);
        chk("tmo_d2_cycles", o_cyc[2], 1);
        // Halt on the timeout edge is not a timeout.
        clr_sched;
        s_h[99] = 1;
        run(99);
        check_run("halt99");
        chk("halt99_d0_to", o_to[0], 0);
        // Early pass from a write in run cycle 7.
        clr_sched;
        s_we[7] = 1; s_addr[7] = 16'hFF; s_data[7] = 16'h0D; s_h[20] = 1;
        run(20);
        check_run("early");
        chk("early_d2_cycles", o_cyc[2], 8);
        chk("early_d2_pass", o_pass[2], 1);
        chk("early_d0_cycles", o_cyc[0], 20);
        // Config and start are ignored while running.
        start = 1; tick; start = 0;
        mem_we = 1; mem_addr = 16'hFF; mem_wdata = 16'h0D; tick;
        mem_we = 0; cfg_we = 1; cfg_idx = 0; cfg_en = 1; cfg_addr = 16'hFF; cfg_data = 16'h99; start = 1; tick;
        cfg_we = 0; start = 0; halt = 1; tick;
        halt = 0; tick;
        chk("runcfg_pass", o_pass[0], 1);
        chk("runcfg_mask", o_fm[0], 0);
        chk("runcfg_cyc", o_cyc[0], 2);
        // Config written on the start edge is used by that run.
        cfg_we = 1; cfg_idx = 0; cfg_en = 1; cfg_addr = 16'h30; cfg_data = 16'h3;
        m_en[0] = 1; m_addr[0] = 16'h30; m_exp[0] = 16'h3;
        clr_sched;
        s_we[0] = 1; s_addr[0] = 16'h30; s_data[0] = 16'h3; s_h[1] = 1;
        run(1);
        check_run("cfgstart");
        chk("cfgstart_d0_pass", o_pass[0], 1);
        // Randomized runs against the reference model.
        for (int r = 0; r < 40; r++) begin
            int h;
            for (int i = 0; i < 4; i++)
                cfg(i, 1'($urandom_range(0, 1)), 16'h40 + 16'($urandom_range(0, 3)), 16'($urandom_range(0, 3)));
            clr_sched;
            h = $urandom_range(0, 110);
            for (int k = 0; k < 100; k++) begin
                s_we[k] = 1'($urandom_range(0, 1));
                s_addr[k] = 16'h40 + 16'($urandom_range(0, 4));
                s_data[k] = 16'($urandom_range(0, 3));
                s_h[k] = (k == h);
            end
            model(0, 0, kx, fm, ps, to);
            run(kx);
            check_run($sformatf("rnd%0d", r));
        end
        // Reset mid-run abandons the run and clears the configuration.
        cfg(0, 1, 16'hFF, 16'h0D);
        start = 1; tick; start = 0;
        mem_we = 1; mem_addr = 16'hFF; mem_wdata = 16'h0D; tick;
        mem_we = 0; tick; tick;
        reset = 0; tick;
        check_zero("midreset");
        reset = 1;
        m_en = 0;
        for (int i = 0; i < 4; i++) begin m_addr[i] = 0; m_exp[i] = 0; end
        clr_sched;
        s_h[2] = 1;
        run(2);
        check_run("nocfg");
        chk("nocfg_d0_pass", o_pass[0], 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
